// File: rtl/mem_wait_gen_if.sv
// rtl/mem_wait_gen_if.sv - memory request / wait-state bus between a core and mem_wait_gen
interface mem_wait_gen_if #(
  parameter int AW = 32
);
  logic          nMREQ;
  logic          SEQ;
  logic          nRW;
  logic [1:0]    MAS;
  logic [AW-1:0] A;
  logic          nWAIT;
  logic          done;
  logic          abort;
  logic          done_rw;

  modport master (
    output nMREQ, SEQ, nRW, MAS, A,
    input  nWAIT, done, abort, done_rw
  );

  modport slave (
    input  nMREQ, SEQ, nRW, MAS, A,
    output nWAIT, done, abort, done_rw
  );
endinterface

// File: rtl/mem_wait_gen.sv
// rtl/mem_wait_gen.sv - per-region N/S wait-state generator with saturating access statistics
module mem_wait_gen #(
  parameter int AW     = 32,
  parameter int NREG   = 4,
  parameter int WW     = 4,
  parameter int CW     = 16,
  parameter int DEF_NW = 1,
  parameter int DEF_SW = 0
) (
  input  logic                    sysclk,
  input  logic                    nRESET,
  mem_wait_gen_if.slave           bus,
  input  logic                    cfg_we,
  input  logic [$clog2(NREG)-1:0] cfg_region,
  input  logic [WW-1:0]           cfg_nw,
  input  logic [WW-1:0]           cfg_sw,
  input  logic                    stat_clr,
  output logic [CW-1:0]           wait_total,
  output logic [CW-1:0]           acc_total
);
  localparam int RB = $clog2(NREG);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [WW-1:0] DEF_N = WW'(DEF_NW);
  localparam logic [WW-1:0] DEF_S = WW'(DEF_SW);
  localparam logic [CW-1:0] CMAX  = '1;

  logic [0:0]    state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic          nwait_q, nwait_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
  logic          done_rw_q, done_rw_d;
  logic          rw_q, rw_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [WW-1:0] nw_q [NREG];
  logic [WW-1:0] nw_d [NREG];
  logic [WW-1:0] sw_q [NREG];
  logic [WW-1:0] sw_d [NREG];

  logic [RB-1:0] region;
  logic          bad;
  logic [WW-1:0] w_sel;
  logic          accept;
  logic          unused_addr;

  assign region      = bus.A[AW-1 -: RB];
  assign unused_addr = ^bus.A;
  // Misaligned or reserved sizes complete immediately and are flagged.
  assign bad    = (bus.MAS == 2'b11) ||
                  (bus.MAS == 2'b01 && bus.A[0]) ||
                  (bus.MAS == 2'b10 && bus.A[1:0] != 2'b00);
  assign w_sel  = bad ? '0 : (bus.SEQ ? sw_q[region] : nw_q[region]);
  assign accept = (state_q == IDLE) && !bus.nMREQ;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nwait_d   = nwait_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    done_rw_d = done_rw_q;
    rw_d      = rw_q;
    if (accept) begin
      rw_d = bus.nRW;
      if (w_sel == '0) begin
        done_d    = 1'b1;
        abort_d   = bad;
        done_rw_d = bus.nRW;
      end else begin
        state_d = WAIT;
        cnt_d   = w_sel;
        nwait_d = 1'b0;
      end
    end else if (state_q == WAIT) begin
      if (cnt_q == WW'(1)) begin
        state_d   = IDLE;
        nwait_d   = 1'b1;
        done_d    = 1'b1;
        done_rw_d = rw_q;
      end else begin
        cnt_d = cnt_q - WW'(1);
      end
    end
  end

  // Config writes land at the edge, so an access accepted at the same edge sees the old counts.
  always_comb begin
    nw_d = nw_q;
    sw_d = sw_q;
    if (cfg_we) begin
      nw_d[cfg_region] = cfg_nw;
      sw_d[cfg_region] = cfg_sw;
    end
  end

  always_comb begin
    wait_d = wait_q;
    acc_d  = acc_q;
    if (!nwait_q && wait_q != CMAX) wait_d = wait_q + CW'(1);
    if (done_q && acc_q != CMAX)    acc_d  = acc_q + CW'(1);
    if (stat_clr) begin
      wait_d = '0;
      acc_d  = '0;
    end
  end

  always_ff @(posedge sysclk or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      nwait_q   <= 1'b1;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      done_rw_q <= 1'b0;
      rw_q      <= 1'b0;
      wait_q    <= '0;
      acc_q     <= '0;
      for (int i = 0; i < NREG; i++) begin
        nw_q[i] <= DEF_N;
        sw_q[i] <= DEF_S;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nwait_q   <= nwait_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      done_rw_q <= done_rw_d;
      rw_q      <= rw_d;
      wait_q    <= wait_d;
      acc_q     <= acc_d;
      nw_q      <= nw_d;
      sw_q      <= sw_d;
    end
  end

  assign bus.nWAIT   = nwait_q;
  assign bus.done    = done_q;
  assign bus.abort   = abort_q;
  assign bus.done_rw = done_rw_q;
  assign wait_total  = wait_q;
  assign acc_total   = acc_q;
endmodule

// File: doc/mem_wait_gen.md
MEM_WAIT_GEN -- requirements
Module: mem_wait_gen

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter NREG, default 4 (power of 2, 2..16): number of wait-state regions, selected by A[AW-1:AW-log2(NREG)].
REQ-003 Parameter WW, default 4: wait-count width; maximum wait per access is 2^WW-1 cycles.
REQ-004 Parameter CW, default 16: statistics counter width.
REQ-005 Parameter DEF_NW, default 1; parameter DEF_SW, default 0: reset N-cycle and S-cycle wait counts for every region.
REQ-006 Port sysclk, input, 1: sole clock, rising edge.
REQ-007 Port nRESET, input, 1: asynchronous active-low reset.
REQ-008 Port nMREQ, input, 1: low = memory request this cycle.
REQ-009 Port SEQ, input, 1: high = sequential (S) cycle; low = non-sequential (N) cycle.
REQ-010 Port nRW, input, 1: 0 = read, 1 = write.
REQ-011 Port MAS, input, 2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-012 Port A, input, AW: request address.
REQ-013 Port cfg_we, input, 1: config write strobe.
REQ-014 Port cfg_region, input, log2(NREG): region being configured.
REQ-015 Port cfg_nw / cfg_sw, input, WW each: new N-cycle / S-cycle wait counts.
REQ-016 Port stat_clr, input, 1: synchronous clear of the statistics counters.
REQ-017 Port nWAIT, output, 1: registered; low stretches the current access.
REQ-018 Port done, output, 1: registered; one-cycle pulse marking access completion.
REQ-019 Port abort, output, 1: registered; valid only with done; marks a misaligned or reserved access.
REQ-020 Port done_rw, output, 1: nRW of the completed access, valid with done.
REQ-021 Port wait_total / acc_total, output, CW each: saturating counts of wait cycles inserted and accesses completed.

Function
REQ-022 The FSM SHALL have two states: IDLE and WAIT.
REQ-023 A request SHALL be accepted at a rising edge when nMREQ=0 and the FSM is in IDLE; address, SEQ, nRW and MAS are captured at that edge.
REQ-024 At acceptance, W SHALL be the selected region's S-wait count if SEQ=1, otherwise its N-wait count.
REQ-025 Misaligned or reserved access SHALL force W=0: MAS=01 with A[0]=1; MAS=10 with A[1:0]!=0; MAS=11 for any address.
REQ-026 W=0: FSM stays IDLE, nWAIT stays 1, and done=1 in the cycle after acceptance.
REQ-027 W>0: FSM enters WAIT and nWAIT=0 for exactly W cycles starting the cycle after acceptance.
REQ-028 W>0 (cont.): nWAIT returns to 1 and done=1 in cycle W+1 after acceptance; the FSM returns to IDLE at that edge.
REQ-029 For an accepted misaligned or reserved access, abort SHALL be 1 with its done pulse; otherwise abort SHALL be 0.
REQ-030 In WAIT, nMREQ/SEQ/nRW/MAS/A SHALL be ignored.
REQ-031 In the done cycle, nMREQ=0 SHALL be accepted as the next request (back-to-back, no idle cycle).
REQ-032 On cfg_we=1, the selected region's counts SHALL update at that edge and apply only to requests accepted at later edges.
REQ-033 cfg_we coincident with an acceptance in the same region SHALL give that access the old counts; an access in progress is never retimed.
REQ-034 wait_total SHALL increment once per cycle with nWAIT=0.
REQ-035 acc_total SHALL increment once per done pulse.
REQ-036 Both statistics counters SHALL saturate at 2^CW-1 and not wrap.
REQ-037 stat_clr SHALL zero both counters; if it coincides with an increment, the clear wins and the result is 0.

Reset
REQ-038 nRESET=0 SHALL immediately force: FSM IDLE, nWAIT=1, done=0, abort=0, done_rw=0, wait_total=0, acc_total=0, all region counts to DEF_NW/DEF_SW.
REQ-039 Reset during WAIT SHALL abandon the access: no done pulse is issued and nWAIT goes to 1 asynchronously.
REQ-040 The first acceptance SHALL occur at the first rising edge with nRESET=1 and nMREQ=0.

Verification
REQ-041 Default config, word read at A=0x100, SEQ=0 -> nWAIT low 1 cycle, done at cycle 2, abort=0, wait_total=1, acc_total=1.
REQ-042 Region 3 configured with N=5, S=2; SEQ=0 access then back-to-back SEQ=1 access at A=0xC000_0000 -> nWAIT low 5 cycles; done; nWAIT low 2 cycles; done; wait_total=7.
REQ-043 MAS=10 at A=0x102 with region wait 7 -> no wait cycles; done with abort=1 in cycle 1. Repeat with MAS=11 and A=0x0 -> same result.
REQ-044 cfg_we on region 0 (N: 1 -> 3) at the acceptance edge -> that access waits 1 cycle; the next access waits 3.
REQ-045 nRESET pulsed low in cycle 2 of a 5-cycle wait -> nWAIT=1 immediately; no done; counters 0; config returns to defaults.
REQ-046 CW=4 with 20 single-wait accesses -> wait_total=15 and acc_total=15 (saturated); then stat_clr -> both 0.
